// File: rtl/dac_link_pkg.sv
// dac_link_pkg: shared constants and FSM encoding for the dual-channel serial DAC link
//   FRAME_BITS_DEF / DATA_W   : frame length and payload width
//   CODE_A_DEF / CODE_B_DEF   : control nibbles selecting channel A / B
//   state_t, ST_*             : receiver FSM encoding
package dac_link_pkg;
  localparam int unsigned FRAME_BITS_DEF = 16;
  localparam int unsigned DATA_W = 12;
  localparam logic [3:0] CODE_A_DEF = 4'b1100;
  localparam logic [3:0] CODE_B_DEF = 4'b0100;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_CHECK = 2'd2;
endpackage

// File: rtl/dac_frame_rx_if.sv
// dac_frame_rx_if: serial link inputs and decoded word outputs of dac_frame_rx
//   cs_i, dclock_i, data_i        : serial link (driven by master)
//   dataa, datab, valid_a/b       : decoded channel words and update pulses
//   frame_err                     : malformed-frame pulse
//   pair_valid, pair_x, pair_y    : X/Y pair outputs, present with DAC_FRAME_RX_PAIR_EN
interface dac_frame_rx_if;
  import dac_link_pkg::*;
  logic cs_i;
  logic dclock_i;
  logic data_i;
  logic [DATA_W-1:0] dataa;
  logic [DATA_W-1:0] datab;
  logic valid_a;
  logic valid_b;
  logic frame_err;
`ifdef DAC_FRAME_RX_PAIR_EN
  logic pair_valid;
  logic [DATA_W-1:0] pair_x;
  logic [DATA_W-1:0] pair_y;
  modport master (
    output cs_i, dclock_i, data_i,
    input dataa, datab, valid_a, valid_b, frame_err, pair_valid, pair_x, pair_y
  );
  modport slave (
    input cs_i, dclock_i, data_i,
    output dataa, datab, valid_a, valid_b, frame_err, pair_valid, pair_x, pair_y
  );
`else
  modport master (
    output cs_i, dclock_i, data_i,
    input dataa, datab, valid_a, valid_b, frame_err
  );
  modport slave (
    input cs_i, dclock_i, data_i,
    output dataa, datab, valid_a, valid_b, frame_err
  );
`endif
endinterface

// File: rtl/sync_edge.sv
// sync_edge: 2-flop synchronizer with a history flop for rise/fall pulse detection
//   clk, reset : clock, async active-high reset
//   d          : asynchronous input
//   q          : synchronized level
//   rise, fall : one-clk pulses on synchronized edges
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic s1_q, s1_d, s2_q, s2_d, h_q, h_d;
  always_comb begin
    s1_d = d;
    s2_d = s1_q;
    h_d = s2_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
      h_q <= RST_VAL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      h_q <= h_d;
    end
  end
  assign q = s2_q;
  assign rise = s2_q & ~h_q;
  assign fall = ~s2_q & h_q;
endmodule

// File: rtl/dac_frame_rx.sv
// dac_frame_rx: oversampling receiver that rebuilds 16-bit DAC link frames into channel A/B words
//   clk, reset : system clock, async active-high reset
//   link       : dac_frame_rx_if.slave (cs_i/dclock_i/data_i in; dataa/datab/valid_a/valid_b/frame_err out)
//   Optional DAC_FRAME_RX_PAIR_EN adds pair_valid/pair_x/pair_y to link.
module dac_frame_rx
  import dac_link_pkg::*;
#(
  parameter logic [3:0] CODE_A = CODE_A_DEF,
  parameter logic [3:0] CODE_B = CODE_B_DEF,
  parameter int unsigned FRAME_BITS = FRAME_BITS_DEF,
  parameter bit SAMPLE_FALL = 1'b1
) (
  input logic clk,
  input logic reset,
  dac_frame_rx_if.slave link
);
  localparam logic [4:0] FB = 5'(FRAME_BITS);
  logic cs_lvl, cs_rise, cs_fall;
  logic dclk_lvl, dclk_rise, dclk_fall;
  logic dat_lvl, dat_rise, dat_fall;
  logic unused_sync;
  logic bit_edge;
  sync_edge #(.RST_VAL(1'b1)) u_cs (
    .clk(clk), .reset(reset), .d(link.cs_i), .q(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );
  sync_edge #(.RST_VAL(1'b0)) u_dclk (
    .clk(clk), .reset(reset), .d(link.dclock_i), .q(dclk_lvl), .rise(dclk_rise), .fall(dclk_fall)
  );
  sync_edge #(.RST_VAL(1'b0)) u_data (
    .clk(clk), .reset(reset), .d(link.data_i), .q(dat_lvl), .rise(dat_rise), .fall(dat_fall)
  );
  assign unused_sync = ^{dclk_lvl, dat_rise, dat_fall};
  assign bit_edge = SAMPLE_FALL ? dclk_fall : dclk_rise;
  state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] sh_q, sh_d;
  logic [DATA_W-1:0] dataa_q, dataa_d, datab_q, datab_d;
  logic valid_a_q, valid_a_d, valid_b_q, valid_b_d, frame_err_q, frame_err_d;
  logic [3:0] nib;
  logic chk, full;
  always_comb begin
    nib = sh_q[FRAME_BITS-1 -: 4];
    chk = state_q == ST_CHECK;
    full = cnt_q == FB;
    valid_a_d = chk & full & (nib == CODE_A);
    valid_b_d = chk & full & (nib == CODE_B) & ~valid_a_d;
    // an empty cs window (no bits) is dropped without an error
    frame_err_d = chk & (cnt_q != 5'd0) & ~valid_a_d & ~valid_b_d;
    dataa_d = valid_a_d ? sh_q[DATA_W-1:0] : dataa_q;
    datab_d = valid_b_d ? sh_q[DATA_W-1:0] : datab_q;
    state_d = state_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    case (state_q)
      ST_IDLE: begin
        state_d = cs_fall ? ST_SHIFT : ST_IDLE;
        cnt_d = '0;
        sh_d = '0;
      end
      ST_SHIFT: begin
        // a bit edge coinciding with the cs rise is still captured
        sh_d = bit_edge ? {sh_q[FRAME_BITS-2:0], dat_lvl} : sh_q;
        cnt_d = (bit_edge && cnt_q != 5'd31) ? cnt_q + 5'd1 : cnt_q;
        state_d = cs_rise ? ST_CHECK : ST_SHIFT;
      end
      ST_CHECK: begin
        state_d = cs_lvl ? ST_IDLE : ST_SHIFT;
        cnt_d = '0;
        sh_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      sh_q <= '0;
      dataa_q <= '0;
      datab_q <= '0;
      valid_a_q <= 1'b0;
      valid_b_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      dataa_q <= dataa_d;
      datab_q <= datab_d;
      valid_a_q <= valid_a_d;
      valid_b_q <= valid_b_d;
      frame_err_q <= frame_err_d;
    end
  end
  assign link.dataa = dataa_q;
  assign link.datab = datab_q;
  assign link.valid_a = valid_a_q;
  assign link.valid_b = valid_b_q;
  assign link.frame_err = frame_err_q;
`ifdef DAC_FRAME_RX_PAIR_EN
  logic pend_b_q, pend_b_d, pair_valid_q, pair_valid_d;
  logic [DATA_W-1:0] pair_x_q, pair_x_d, pair_y_q, pair_y_d;
  // channel B arrives first and is X; the following channel A word closes the pair as Y
  always_comb begin
    pair_valid_d = valid_a_q & pend_b_q;
    pair_x_d = pair_valid_d ? datab_q : pair_x_q;
    pair_y_d = pair_valid_d ? dataa_q : pair_y_q;
    pend_b_d = frame_err_q ? 1'b0 : valid_b_q ? 1'b1 : pair_valid_d ? 1'b0 : pend_b_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_b_q <= 1'b0;
      pair_valid_q <= 1'b0;
      pair_x_q <= '0;
      pair_y_q <= '0;
    end else begin
      pend_b_q <= pend_b_d;
      pair_valid_q <= pair_valid_d;
      pair_x_q <= pair_x_d;
      pair_y_q <= pair_y_d;
    end
  end
  assign link.pair_valid = pair_valid_q;
  assign link.pair_x = pair_x_q;
  assign link.pair_y = pair_y_q;
`endif
endmodule

// File: tb/tb_dac_frame_rx.sv
// tb_dac_frame_rx: table-driven self-checking bench for dac_frame_rx
module tb_dac_frame_rx;
  import dac_link_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  dac_frame_rx_if link();
  dac_frame_rx dut (.clk(clk), .reset(reset), .link(link));
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] w;
    int nbits;
    bit simul;
    int ea;
    int eb;
    int ee;
    logic [11:0] xa;
    logic [11:0] xb;
  } vec_t;
  vec_t tv[9];

  int cyc = 0, errors = 0, checks = 0;
  int na = 0, nb = 0, ne = 0, np = 0, excl = 0;
  int last_a = 0, last_b = 0, last_e = 0, last_p = 0, rise_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (link.valid_a) begin na <= na + 1; last_a <= cyc; end
    if (link.valid_b) begin nb <= nb + 1; last_b <= cyc; end
    if (link.frame_err) begin ne <= ne + 1; last_e <= cyc; end
    if (int'(link.valid_a) + int'(link.valid_b) + int'(link.frame_err) > 1) excl <= excl + 1;
`ifdef DAC_FRAME_RX_PAIR_EN
    if (link.pair_valid) begin np <= np + 1; last_p <= cyc; end
`endif
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [15:0] w, input int nbits, input bit simul);
    link.cs_i = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      link.data_i = (i < 16) ? w[15-i] : 1'b0;
      link.dclock_i = 1'b1;
      repeat (4) @(negedge clk);
      if (simul && i == nbits - 1) begin
        link.dclock_i = 1'b0;
        link.cs_i = 1'b1;
        rise_cyc = cyc;
        return;
      end
      link.dclock_i = 1'b0;
      repeat (4) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    link.cs_i = 1'b1;
    rise_cyc = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int a0, b0, e0, p0;
    logic [15:0] w;
    link.cs_i = 1'b1;
    link.dclock_i = 1'b0;
    link.data_i = 1'b0;
    tv[0] = '{16'hCA5C, 16, 1'b0, 1, 0, 0, 12'hA5C, 12'h000};
    tv[1] = '{16'h4123, 16, 1'b0, 0, 1, 0, 12'hA5C, 12'h123};
    tv[2] = '{16'hC456, 16, 1'b0, 1, 0, 0, 12'h456, 12'h123};
    tv[3] = '{16'hC777, 15, 1'b0, 0, 0, 1, 12'h456, 12'h123};
    tv[4] = '{16'hC777, 20, 1'b0, 0, 0, 1, 12'h456, 12'h123};
    tv[5] = '{16'h0000, 0, 1'b0, 0, 0, 0, 12'h456, 12'h123};
    tv[6] = '{16'h3FFF, 16, 1'b0, 0, 0, 1, 12'h456, 12'h123};
    tv[7] = '{16'h4ABC, 16, 1'b0, 0, 1, 0, 12'h456, 12'hABC};
    tv[8] = '{16'hC3C3, 16, 1'b1, 1, 0, 0, 12'h3C3, 12'hABC};
    repeat (3) @(negedge clk);
    chk("reset dataa", link.dataa, 0);
    chk("reset datab", link.datab, 0);
    chk("reset valid_a", link.valid_a, 0);
    chk("reset valid_b", link.valid_b, 0);
    chk("reset frame_err", link.frame_err, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 9; k++) begin
      a0 = na; b0 = nb; e0 = ne;
      send_frame(tv[k].w, tv[k].nbits, tv[k].simul);
      repeat (12) @(negedge clk);
      chk($sformatf("v%0d valid_a count", k), na - a0, tv[k].ea);
      chk($sformatf("v%0d valid_b count", k), nb - b0, tv[k].eb);
      chk($sformatf("v%0d frame_err count", k), ne - e0, tv[k].ee);
      chk($sformatf("v%0d dataa", k), link.dataa, tv[k].xa);
      chk($sformatf("v%0d datab", k), link.datab, tv[k].xb);
      if (tv[k].ea != 0) chk($sformatf("v%0d valid_a latency", k), last_a - rise_cyc, 4);
      if (tv[k].eb != 0) chk($sformatf("v%0d valid_b latency", k), last_b - rise_cyc, 4);
      if (tv[k].ee != 0) chk($sformatf("v%0d frame_err latency", k), last_e - rise_cyc, 4);
    end
    a0 = na; b0 = nb; e0 = ne;
    send_frame(16'h4123, 16, 1'b0);
    repeat (3) @(negedge clk);
    send_frame(16'hC456, 16, 1'b0);
    repeat (12) @(negedge clk);
    chk("b2b valid_b count", nb - b0, 1);
    chk("b2b valid_a count", na - a0, 1);
    chk("b2b frame_err count", ne - e0, 0);
    chk("b2b datab", link.datab, 12'h123);
    chk("b2b dataa", link.dataa, 12'h456);
    chk("b2b order", last_a > last_b, 1);
    w = 16'hC800;
    link.cs_i = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      link.data_i = w[15-i];
      link.dclock_i = 1'b1;
      repeat (4) @(negedge clk);
      link.dclock_i = 1'b0;
      repeat (4) @(negedge clk);
    end
    reset = 1'b1;
    link.cs_i = 1'b1;
    link.data_i = 1'b0;
    @(negedge clk);
    chk("midreset dataa", link.dataa, 0);
    chk("midreset datab", link.datab, 0);
    chk("midreset valid_a", link.valid_a, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    a0 = na; b0 = nb; e0 = ne;
    send_frame(16'hC001, 16, 1'b0);
    repeat (12) @(negedge clk);
    chk("post-reset valid_a count", na - a0, 1);
    chk("post-reset frame_err count", ne - e0, 0);
    chk("post-reset dataa", link.dataa, 12'h001);
    chk("post-reset datab", link.datab, 12'h000);
`ifdef DAC_FRAME_RX_PAIR_EN
    p0 = np;
    send_frame(16'h4111, 16, 1'b0);
    repeat (12) @(negedge clk);
    send_frame(16'hC222, 16, 1'b0);
    repeat (12) @(negedge clk);
    chk("pair count", np - p0, 1);
    chk("pair_x", link.pair_x, 12'h111);
    chk("pair_y", link.pair_y, 12'h222);
    chk("pair delay", last_p - last_a, 1);
    send_frame(16'hC333, 16, 1'b0);
    repeat (12) @(negedge clk);
    chk("pair count after lone A", np - p0, 1);
    chk("pair_y hold", link.pair_y, 12'h222);
`else
    p0 = 0;
    chk("pair count disabled", np, p0);
`endif
    chk("pulse exclusivity", excl, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
